parking_gate_ctrl: RTL and testbench

Parametrised next-generation parking entry controller. It adds four things to the single-gate, fixed-PIN design:
- a handshaked PIN entry with a configurable number of tries,
- a PIN-entry timeout,
- a lot-occupancy counter with full detection,
- an exit port.

It sits between the entry sensors, keypad interface and gate actuator, and reports alarms and occupancy to the supervisory logic.

---
 rtl/parking_pkg.sv | 28 ++
 rtl/parking_occupancy_counter.sv | 65 ++++++
 rtl/parking_gate_ctrl.sv | 174 +++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared types and width helpers for the parking entry controller.
//   state_e : one-hot FSM state encoding (5 states, 5 bits)
//   occ_w() : width of the occupancy counter for a given lot capacity
//   try_w() : width of the tries counter for a given MAX_TRIES
// -----------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    WAIT_PIN = 5'b00010,
    OPEN     = 5'b00100,
    LOCKED   = 5'b01000,
    BLOCKED  = 5'b10000
  } state_e;

  // Bits needed to hold 0..capacity inclusive.
  function automatic int occ_w(input int capacity);
    return $clog2(capacity + 1);
  endfunction

  // Bits needed to hold 0..max_tries inclusive.
  function automatic int try_w(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// -----------------------------------------------------------------------------
// parking_occupancy_counter
// Saturating up/down counter of cars in the lot.
//   clk, rst_n : clock, synchronous active-low reset
//   inc_i      : a car entered (saturates at CAPACITY)
//   dec_i      : a car left (saturates at 0)
//   count_o    : registered occupancy
//   full_o     : registered (count == CAPACITY), taken from the updated count
// Simultaneous inc_i and dec_i cancel and leave the count unchanged.
// -----------------------------------------------------------------------------
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc_i,
  input  logic                         dec_i,
  output logic [occ_w(CAPACITY)-1:0]   count_o,
  output logic                         full_o
);

  localparam int OCC_W = occ_w(CAPACITY);
  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] count_d;
  logic             full_q;

  // Next count with saturation at both ends.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      if (count_q != CAP) begin
        count_d = count_q + OCC_W'(1);
      end else begin
        count_d = count_q;
      end
    end else if (dec_i && !inc_i) begin
      if (count_q != {OCC_W{1'b0}}) begin
        count_d = count_q - OCC_W'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count and full registers; full tracks the value being loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {OCC_W{1'b0}};
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CAP);
    end
  end

  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
// Parking entry controller: PIN-gated entry with limited tries and timeout,
// obstruction detection and lot occupancy tracking.
//   clk, rst_n        : clock, synchronous active-low reset
//   sensor_a          : car present at entry
//   sensor_b          : car past gate
//   pin_valid, pin    : one-cycle strobe qualifying the entered PIN
//   car_exit          : one-cycle pulse, a car left the lot
//   gate_open         : gate actuator command (state OPEN)
//   wrong_pin_alarm   : lockout alarm (state LOCKED)
//   block_alarm       : obstruction/tailgating alarm (state BLOCKED)
//   full, occupancy   : lot status
//   tries_left        : MAX_TRIES minus wrong PINs in the current entry
// All outputs are registered; they reflect the state entered at the last edge.
// -----------------------------------------------------------------------------
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int                   PIN_WIDTH = 8,
  parameter logic [PIN_WIDTH-1:0] PIN_VALUE = 8'h26,
  parameter int                   MAX_TRIES = 3,
  parameter int                   CAPACITY  = 16,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sensor_a,
  input  logic                          sensor_b,
  input  logic                          pin_valid,
  input  logic [PIN_WIDTH-1:0]          pin,
  input  logic                          car_exit,
  output logic                          gate_open,
  output logic                          wrong_pin_alarm,
  output logic                          block_alarm,
  output logic                          full,
  output logic [occ_w(CAPACITY)-1:0]    occupancy,
  output logic [try_w(MAX_TRIES)-1:0]   tries_left
);

  localparam int TRY_W = try_w(MAX_TRIES);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TRY_W-1:0] MAX_T    = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TRY_W-1:0] tries_inc_s;
  logic             gate_open_q, wrong_pin_q, block_q;
  logic [TRY_W-1:0] tries_left_q;
  logic             pin_match_s, obstruct_s, inc_s, full_s;

  assign pin_match_s = pin_valid && (pin == PIN_VALUE);
  assign obstruct_s  = sensor_a && sensor_b;
  assign tries_inc_s = tries_q + TRY_W'(1);

  // Next-state, tries/timer update and occupancy increment request.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = timer_q;
    inc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (obstruct_s) begin
          state_d = BLOCKED;
        end else if (sensor_a && !sensor_b && !full_s) begin
          state_d = WAIT_PIN;
          tries_d = {TRY_W{1'b0}};
          timer_d = {TMR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_PIN: begin
        if (obstruct_s) begin
          state_d = BLOCKED;
        end else if (pin_match_s) begin
          state_d = OPEN;
        end else if (pin_valid) begin
          // Wrong PIN: count it and restart the timeout window.
          tries_d = tries_inc_s;
          timer_d = {TMR_W{1'b0}};
          if (tries_inc_s == MAX_T) begin
            state_d = LOCKED;
          end else if (!sensor_a) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_PIN;
          end
        end else if (!sensor_a) begin
          state_d = IDLE;
        end else if (timer_q == TMO_LAST) begin
          // This is the TIMEOUT-th idle cycle spent in WAIT_PIN.
          state_d = IDLE;
          timer_d = {TMR_W{1'b0}};
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OPEN: begin
        if (obstruct_s) begin
          state_d = BLOCKED;
        end else if (sensor_b && !sensor_a) begin
          state_d = IDLE;
          inc_s   = 1'b1;
        end else begin
          state_d = OPEN;
        end
      end
      LOCKED: begin
        if (pin_match_s) begin
          state_d = IDLE;
          tries_d = {TRY_W{1'b0}};
        end else begin
          state_d = LOCKED;
        end
      end
      BLOCKED: begin
        if (pin_match_s) begin
          state_d = IDLE;
        end else begin
          state_d = BLOCKED;
        end
      end
      default: begin
        // Corrupted one-hot state: recover to a safe, closed gate.
        state_d = IDLE;
        tries_d = {TRY_W{1'b0}};
        timer_d = {TMR_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tries_q      <= {TRY_W{1'b0}};
      timer_q      <= {TMR_W{1'b0}};
      gate_open_q  <= 1'b0;
      wrong_pin_q  <= 1'b0;
      block_q      <= 1'b0;
      tries_left_q <= MAX_T;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      timer_q      <= timer_d;
      gate_open_q  <= (state_d == OPEN);
      wrong_pin_q  <= (state_d == LOCKED);
      block_q      <= (state_d == BLOCKED);
      tries_left_q <= MAX_T - tries_d;
    end
  end

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inc_s),
    .dec_i   (car_exit),
    .count_o (occupancy),
    .full_o  (full_s)
  );

  assign gate_open       = gate_open_q;
  assign wrong_pin_alarm = wrong_pin_q;
  assign block_alarm     = block_q;
  assign full            = full_s;
  assign tries_left      = tries_left_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
// Directed bench for parking_gate_ctrl with default parameters
// (PIN 8'h26, 3 tries, capacity 16, timeout 255).
// -----------------------------------------------------------------------------
module tb_parking_gate_ctrl;

  localparam int TMO = 255;
  localparam logic [7:0] GOOD = 8'h26;

  logic       clk;
  logic       rst_n;
  logic       sensor_a, sensor_b, pin_valid, car_exit;
  logic [7:0] pin;
  logic       gate_open, wrong_pin_alarm, block_alarm, full;
  logic [4:0] occupancy;
  logic [1:0] tries_left;

  int checks = 0;
  int passed = 0;
  int occ_m  = 0;

  typedef struct {
    logic       sa, sb, pv;
    logic [7:0] p;
    logic       ce, rn;
    logic [3:0] flags;   // {gate_open, wrong_pin_alarm, block_alarm, full}
    logic [4:0] occ;
    logic [1:0] tl;
  } vec_t;

  vec_t vq[$];

  parking_gate_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sensor_a        (sensor_a),
    .sensor_b        (sensor_b),
    .pin_valid       (pin_valid),
    .pin             (pin),
    .car_exit        (car_exit),
    .gate_open       (gate_open),
    .wrong_pin_alarm (wrong_pin_alarm),
    .block_alarm     (block_alarm),
    .full            (full),
    .occupancy       (occupancy),
    .tries_left      (tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic sa, input logic sb, input logic pv, input logic [7:0] p,
                     input logic ce, input logic rn, input logic [3:0] flags,
                     input logic [4:0] occ, input logic [1:0] tl);
    vec_t v;
    v.sa = sa; v.sb = sb; v.pv = pv; v.p = p; v.ce = ce; v.rn = rn;
    v.flags = flags; v.occ = occ; v.tl = tl;
    vq.push_back(v);
  endtask

  // Apply inputs for one cycle and sample outputs 1 time unit after the edge.
  task automatic drive(input logic sa, input logic sb, input logic pv, input logic [7:0] p,
                       input logic ce, input logic rn);
    sensor_a  = sa;
    sensor_b  = sb;
    pin_valid = pv;
    pin       = p;
    car_exit  = ce;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [3:0] ef,
                            input logic [4:0] eo, input logic [1:0] et);
    logic [3:0] af;
    af = {gate_open, wrong_pin_alarm, block_alarm, full};
    checks++;
    if (af !== ef || occupancy !== eo || tries_left !== et) begin
      $display("FAIL %s: got flags(g,w,b,f)=%b occ=%0d tries_left=%0d, expected flags=%b occ=%0d tries_left=%0d",
               name, af, occupancy, tries_left, ef, eo, et);
    end else begin
      passed++;
    end
  endtask

  // Full entry: arrive, good PIN, pass the gate (optionally with a car_exit).
  task automatic do_entry(input logic ce);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_outs("entry_wait", {3'b000, occ_m == 16}, 5'(occ_m), 2'd3);
    drive(1'b1, 1'b0, 1'b1, GOOD, 1'b0, 1'b1);
    check_outs("entry_open", {3'b100, occ_m == 16}, 5'(occ_m), 2'd3);
    drive(1'b0, 1'b1, 1'b0, 8'h00, ce, 1'b1);
    if (!ce && occ_m < 16) occ_m++;
    check_outs("entry_pass", {3'b000, occ_m == 16}, 5'(occ_m), 2'd3);
  endtask

  initial begin
    sensor_a = 1'b0; sensor_b = 1'b0; pin_valid = 1'b0; pin = 8'h00;
    car_exit = 1'b0; rst_n = 1'b0;

    //  sa    sb    pv    pin    ce    rn    flags    occ  tl
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 5'd0, 2'd3); // reset
    // basic entry
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd0, 2'd3);
    add(1'b1, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b1000, 5'd0, 2'd3);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    // three wrong PINs -> lockout
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd2);
    add(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd1);
    add(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 4'b0100, 5'd1, 2'd0);
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0100, 5'd1, 2'd0); // sensors ignored
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0100, 5'd1, 2'd0); // wrong PIN ignored
    add(1'b0, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    // obstruction during OPEN
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    add(1'b1, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b1000, 5'd1, 2'd3);
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0010, 5'd1, 2'd3);
    add(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 4'b0010, 5'd1, 2'd3);
    add(1'b0, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    // obstruction during WAIT_PIN
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0010, 5'd1, 2'd3);
    add(1'b0, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    // raise occupancy to 5
    for (int k = 2; k <= 5; k++) begin
      add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'(k - 1), 2'd3);
      add(1'b1, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b1000, 5'(k - 1), 2'd3);
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'(k),     2'd3);
    end
    // reset while OPEN at occupancy 5
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd5, 2'd3);
    add(1'b1, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b1000, 5'd5, 2'd3);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 5'd0, 2'd3);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 5'd0, 2'd3); // exit at 0 saturates
    // one car in, one car out
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd0, 2'd3);
    add(1'b1, 1'b0, 1'b1, GOOD,  1'b0, 1'b1, 4'b1000, 5'd0, 2'd3);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 5'd1, 2'd3);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 5'd0, 2'd3);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sa, vq[i].sb, vq[i].pv, vq[i].p, vq[i].ce, vq[i].rn);
      check_outs($sformatf("vec%0d", i), vq[i].flags, vq[i].occ, vq[i].tl);
    end
    occ_m = 0;

    // Car withdraws in WAIT_PIN: a good PIN next cycle must not open the gate.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, GOOD,  1'b0, 1'b1);
    check_outs("withdraw_idle", 4'b0000, 5'd0, 2'd3);

    // Timeout: TIMEOUT-1 idle cycles in WAIT_PIN still accept the PIN.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i < TMO; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, GOOD, 1'b0, 1'b1);
    check_outs("timeout_not_yet", 4'b1000, 5'd0, 2'd3);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    occ_m = 1;
    check_outs("timeout_pass", 4'b0000, 5'd1, 2'd3);

    // Timeout: TIMEOUT idle cycles return to IDLE, so the PIN is ignored.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= TMO; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, GOOD, 1'b0, 1'b1);
    check_outs("timeout_expired", 4'b0000, 5'd1, 2'd3);

    // Fill the lot.
    while (occ_m < 15) do_entry(1'b0);
    do_entry(1'b1);                       // entry + exit together: stays 15
    check_outs("inc_dec_same_cycle", 4'b0000, 5'd15, 2'd3);
    do_entry(1'b0);                       // 16 -> full
    check_outs("lot_full", 4'b0001, 5'd16, 2'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_outs("full_arrival", 4'b0001, 5'd16, 2'd3);
    drive(1'b1, 1'b0, 1'b1, GOOD, 1'b0, 1'b1);
    check_outs("full_no_open", 4'b0001, 5'd16, 2'd3);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check_outs("exit_from_full", 4'b0000, 5'd15, 2'd3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
